// File: rtl/uop_cracker_pkg.sv
// Shared types for the micro-op cracker: register ids, opcodes, the fat
// instruction from the decoder and the micro-op handed to register read.
package uop_cracker_pkg;

    typedef logic [4:0] reg_id_t;
    localparam reg_id_t UOP_TMP_REG = 5'd16;
    localparam reg_id_t UOP_NO_REG  = 5'd31;

    typedef enum logic [5:0] {
        m_nop     = 6'd0,
        m_add     = 6'd1,
        m_sub     = 6'd2,
        m_and     = 6'd3,
        m_or      = 6'd4,
        m_xor     = 6'd5,
        m_cpy     = 6'd6,
        m_lea     = 6'd7,
        m_ld      = 6'd8,
        m_st      = 6'd9,
        m_syscall = 6'd10,
        m_jmp     = 6'd16,
        m_jz      = 6'd17,
        m_jnz     = 6'd18
    } micro_opcode_t;

    localparam micro_opcode_t M_JMIN = m_jmp;
    localparam micro_opcode_t M_JMAX = m_jnz;

    typedef enum logic [1:0] {OPND_NIL, OPND_REG, OPND_IMM, OPND_MEM} opnd_kind_t;

    typedef struct packed {
        opnd_kind_t kind;
        reg_id_t    base_reg;
        reg_id_t    index_reg;
    } operand_t;

    typedef struct packed {
        operand_t    operand0;
        operand_t    operand1;
        logic [1:0]  scale;
        logic [31:0] disp;
        logic [31:0] immediate;
        logic [31:0] rip_val;
    } fat_instruction_t;

    typedef struct packed {
        micro_opcode_t opcode;
        reg_id_t       dst_id;
        reg_id_t       src0_id;
        reg_id_t       src1_id;
        logic [31:0]   src0_val;
        logic [31:0]   src1_val;
        logic [31:0]   dst_val;
        logic [1:0]    scale;
        logic [31:0]   disp;
        logic [31:0]   immediate;
        logic [31:0]   rip_val;
    } micro_op_t;

    typedef enum logic [1:0] {SINGLE, LD_OP, LD_OP_ST, ILLEGAL} uop_crack_kind_t;

    typedef enum logic [2:0] {
        SEL_OP0_BASE, SEL_OP0_INDEX, SEL_OP1_BASE, SEL_OP1_INDEX,
        SEL_OP1_OR_NO, SEL_OP1_DATA, SEL_TMP
    } reg_sel_t;

    typedef enum logic {ST_IDLE, ST_EMIT} state_t;

    function automatic reg_id_t pick_reg(reg_sel_t sel, fat_instruction_t inst);
        reg_id_t r;
        case (sel)
            SEL_OP0_BASE:  r = inst.operand0.base_reg;
            SEL_OP0_INDEX: r = inst.operand0.index_reg;
            SEL_OP1_BASE:  r = inst.operand1.base_reg;
            SEL_OP1_INDEX: r = inst.operand1.index_reg;
            SEL_OP1_OR_NO: r = (inst.operand1.kind == OPND_NIL) ? UOP_NO_REG : inst.operand1.base_reg;
            // Store data: only a register source is read; an immediate travels in the uop.
            SEL_OP1_DATA:  r = (inst.operand1.kind == OPND_REG) ? inst.operand1.base_reg : UOP_NO_REG;
            SEL_TMP:       r = UOP_TMP_REG;
            default:       r = UOP_NO_REG;
        endcase
        return r;
    endfunction

    function automatic micro_op_t build_uop(micro_opcode_t opc, reg_sel_t dst_sel,
                                            reg_sel_t src0_sel, reg_sel_t src1_sel,
                                            fat_instruction_t inst);
        micro_op_t u;
        u           = '0;
        u.opcode    = opc;
        u.dst_id    = pick_reg(dst_sel, inst);
        u.src0_id   = pick_reg(src0_sel, inst);
        u.src1_id   = pick_reg(src1_sel, inst);
        u.scale     = inst.scale;
        u.disp      = inst.disp;
        u.immediate = inst.immediate;
        u.rip_val   = inst.rip_val;
        return u;
    endfunction

endpackage

// File: rtl/uop_cracker_rom.sv
// Combinational crack table: decides the crack kind, sequence length and,
// for one index, which opcode and register selectors the uop uses.
module uop_crack_rom
    import uop_cracker_pkg::*;
(
    input  micro_opcode_t   alu_op,
    input  opnd_kind_t      op0_kind,
    input  opnd_kind_t      op1_kind,
    input  logic [1:0]      idx,
    output micro_opcode_t   opcode,
    output reg_sel_t        dst_sel,
    output reg_sel_t        src0_sel,
    output reg_sel_t        src1_sel,
    output logic [1:0]      n,
    output uop_crack_kind_t kind
);

    logic op0_mem, op1_mem, is_ctrl;

    assign op0_mem = (op0_kind == OPND_MEM);
    assign op1_mem = (op1_kind == OPND_MEM);
    assign is_ctrl = ((alu_op >= M_JMIN) && (alu_op <= M_JMAX)) ||
                     (alu_op == m_syscall) || (alu_op == m_lea);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        kind     = SINGLE;
        n        = 2'd1;
        opcode   = alu_op;
        dst_sel  = SEL_OP0_BASE;
        src0_sel = SEL_OP0_BASE;
        src1_sel = SEL_OP1_OR_NO;

        if (op0_mem && op1_mem) begin
            kind = ILLEGAL;
        end else if (is_ctrl || !(op0_mem || op1_mem)) begin
            kind = SINGLE;
        end else if (alu_op == m_cpy) begin
            if (op1_mem) begin
                opcode   = m_ld;
                src0_sel = SEL_OP1_BASE;
                src1_sel = SEL_OP1_INDEX;
            end else begin
                opcode   = m_st;
                dst_sel  = SEL_OP1_DATA;
                src1_sel = SEL_OP0_INDEX;
            end
        end else if (op1_mem) begin
            kind = LD_OP;
            n    = 2'd2;
            if (idx == 2'd0) begin
                opcode   = m_ld;
                dst_sel  = SEL_TMP;
                src0_sel = SEL_OP1_BASE;
                src1_sel = SEL_OP1_INDEX;
            end else begin
                src1_sel = SEL_TMP;
            end
        end else begin
            kind     = LD_OP_ST;
            n        = 2'd3;
            dst_sel  = SEL_TMP;
            src0_sel = SEL_OP0_BASE;
            src1_sel = SEL_OP0_INDEX;
            case (idx)
                2'd0:    opcode = m_ld;
                2'd1: begin
                    src0_sel = SEL_TMP;
                    src1_sel = SEL_OP1_OR_NO;
                end
                default: opcode = m_st;
            endcase
        end
    end

endmodule

// File: rtl/uop_cracker.sv
// Cracks one decoded instruction into 1-3 micro-ops, emitted one per cycle
// on a registered valid/ready stream; memory+ALU forms go through the temp reg.
module uop_cracker
    import uop_cracker_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  fat_instruction_t in_inst,
    input  micro_opcode_t    in_alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output micro_op_t        out_uop,
    output logic             out_last,
    output logic             err_illegal
);

    state_t           state_q, state_d;
    fat_instruction_t inst_q, inst_d;
    micro_opcode_t    alu_op_q, alu_op_d;
    logic [1:0]       idx_q, idx_d, n_q, n_d;
    micro_op_t        uop_q, uop_d;
    logic             last_q, last_d, err_q, err_d;

    fat_instruction_t rom_inst;
    micro_opcode_t    rom_alu_op, rom_opcode;
    logic [1:0]       rom_idx, rom_n;
    reg_sel_t         rom_dst_sel, rom_src0_sel, rom_src1_sel;
    uop_crack_kind_t  rom_kind;
    logic             accept, accept_legal, out_fire, advance;

    assign accept       = in_valid && in_ready;
    assign accept_legal = accept && (rom_kind != ILLEGAL);
    assign out_fire     = out_valid && out_ready;
    assign advance      = out_fire && !last_q;

    // The table sees the incoming instruction when one is taken, else the held one at idx+1.
    always_comb begin
        rom_inst   = inst_q;
        rom_alu_op = alu_op_q;
        rom_idx    = idx_q + 2'd1;
        if (accept) begin
            rom_inst   = in_inst;
            rom_alu_op = in_alu_op;
            rom_idx    = 2'd0;
        end
    end

    uop_crack_rom u_rom (
        .alu_op   (rom_alu_op),
        .op0_kind (rom_inst.operand0.kind),
        .op1_kind (rom_inst.operand1.kind),
        .idx      (rom_idx),
        .opcode   (rom_opcode),
        .dst_sel  (rom_dst_sel),
        .src0_sel (rom_src0_sel),
        .src1_sel (rom_src1_sel),
        .n        (rom_n),
        .kind     (rom_kind)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_legal) state_d = ST_EMIT;
            ST_EMIT: if (out_fire && last_q) state_d = accept_legal ? ST_EMIT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_EMIT);
        in_ready  = (state_q == ST_IDLE) || (out_valid && out_ready && last_q);
    end

    always_comb begin
        inst_d   = inst_q;
        alu_op_d = alu_op_q;
        n_d      = n_q;
        idx_d    = idx_q;
        uop_d    = uop_q;
        last_d   = last_q;
        err_d    = accept && (rom_kind == ILLEGAL);
        if (accept_legal) begin
            inst_d   = in_inst;
            alu_op_d = in_alu_op;
            n_d      = rom_n;
        end
        if (accept_legal || advance) begin
            idx_d  = rom_idx;
            uop_d  = build_uop(rom_opcode, rom_dst_sel, rom_src0_sel, rom_src1_sel, rom_inst);
            last_d = (rom_idx == n_d - 2'd1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            inst_q   <= '0;
            alu_op_q <= m_nop;
            n_q      <= 2'd0;
            idx_q    <= 2'd0;
            uop_q    <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            inst_q   <= inst_d;
            alu_op_q <= alu_op_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            uop_q    <= uop_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    assign out_uop     = uop_q;
    assign out_last    = last_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_uop_cracker.sv
// Directed bench for uop_cracker: inputs change just after the falling edge,
// outputs are sampled 1ns later, well away from the rising edge.
module tb_uop_cracker;
    import uop_cracker_pkg::*;

    localparam reg_id_t RAX = 5'd0, RCX = 5'd1, RDX = 5'd2, RBX = 5'd3;
    localparam reg_id_t RBP = 5'd5, RSI = 5'd6, RDI = 5'd7;
    localparam reg_id_t NOR = UOP_NO_REG, TMP = UOP_TMP_REG;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid, in_ready, out_valid, out_ready, out_last, err_illegal;
    fat_instruction_t in_inst;
    micro_opcode_t    in_alu_op;
    micro_op_t        out_uop;

    int total = 0;
    int bad   = 0;

    uop_cracker dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_alu_op   (in_alu_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_uop     (out_uop),
        .out_last    (out_last),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    function automatic operand_t mk_opnd(opnd_kind_t k, reg_id_t b, reg_id_t i);
        operand_t o;
        o.kind = k; o.base_reg = b; o.index_reg = i;
        return o;
    endfunction

    function automatic fat_instruction_t mk_inst(operand_t o0, operand_t o1, logic [1:0] sc,
                                                 logic [31:0] dp, logic [31:0] imm, logic [31:0] rip);
        fat_instruction_t f;
        f.operand0 = o0; f.operand1 = o1; f.scale = sc;
        f.disp = dp; f.immediate = imm; f.rip_val = rip;
        return f;
    endfunction

    function automatic micro_op_t mk_uop(micro_opcode_t opc, reg_id_t d, reg_id_t s0, reg_id_t s1,
                                         fat_instruction_t f);
        micro_op_t u;
        u = '0;
        u.opcode = opc; u.dst_id = d; u.src0_id = s0; u.src1_id = s1;
        u.scale = f.scale; u.disp = f.disp; u.immediate = f.immediate; u.rip_val = f.rip_val;
        return u;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_alu_op = m_nop;
        repeat (3) @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        reset_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (out_uop !== micro_op_t'('0)) begin bad++; $display("FAIL rst_out_uop got=%h exp=0", out_uop); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
        total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_illegal); end
    endtask

    task automatic test_reg_add();
        fat_instruction_t f;
        micro_op_t        e;
        f = mk_inst(mk_opnd(OPND_REG, RAX, NOR), mk_opnd(OPND_REG, RBX, NOR), 2'd0, 32'h0, 32'h0, 32'h100);
        e = mk_uop(m_add, RAX, RAX, RBX, f);
        in_inst = f; in_alu_op = m_add; in_valid = 1'b1; out_ready = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready got=%b exp=1", in_ready); end
        next_cycle();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        total++; if (out_uop !== e) begin bad++; $display("FAIL add_uop got=%h exp=%h", out_uop, e); end
        total++; if (out_last !== 1'b1) begin bad++; $display("FAIL add_last got=%b exp=1", out_last); end
        next_cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_done got=%b exp=0", out_valid); end
    endtask

    // Table of cracked forms: load-op, read-modify-write, cpy load/store, jump, lea.
    task automatic test_crack_forms();
        fat_instruction_t vi [6];
        micro_opcode_t    vo [6];
        int               vn [6];
        micro_op_t        ve [6][3];
        vi[0] = mk_inst(mk_opnd(OPND_REG, RCX, NOR), mk_opnd(OPND_MEM, RSI, RDI), 2'd2, 32'h10, 32'h0, 32'h200);
        vo[0] = m_sub; vn[0] = 2;
        ve[0][0] = mk_uop(m_ld, TMP, RSI, RDI, vi[0]);
        ve[0][1] = mk_uop(m_sub, RCX, RCX, TMP, vi[0]);
        vi[1] = mk_inst(mk_opnd(OPND_MEM, RBP, NOR), mk_opnd(OPND_IMM, NOR, NOR), 2'd0, 32'hFFFF_FFF8, 32'hFF, 32'h300);
        vo[1] = m_or; vn[1] = 3;
        ve[1][0] = mk_uop(m_ld, TMP, RBP, NOR, vi[1]);
        ve[1][1] = mk_uop(m_or, TMP, TMP, NOR, vi[1]);
        ve[1][2] = mk_uop(m_st, TMP, RBP, NOR, vi[1]);
        vi[2] = mk_inst(mk_opnd(OPND_REG, RAX, NOR), mk_opnd(OPND_MEM, RBX, RCX), 2'd3, 32'h20, 32'h0, 32'h400);
        vo[2] = m_cpy; vn[2] = 1;
        ve[2][0] = mk_uop(m_ld, RAX, RBX, RCX, vi[2]);
        vi[3] = mk_inst(mk_opnd(OPND_MEM, RDI, NOR), mk_opnd(OPND_REG, RDX, NOR), 2'd0, 32'h4, 32'h0, 32'h500);
        vo[3] = m_cpy; vn[3] = 1;
        ve[3][0] = mk_uop(m_st, RDX, RDI, NOR, vi[3]);
        vi[4] = mk_inst(mk_opnd(OPND_MEM, RAX, NOR), mk_opnd(OPND_NIL, RBX, NOR), 2'd0, 32'h0, 32'h0, 32'h600);
        vo[4] = m_jz; vn[4] = 1;
        ve[4][0] = mk_uop(m_jz, RAX, RAX, NOR, vi[4]);
        vi[5] = mk_inst(mk_opnd(OPND_REG, RDX, NOR), mk_opnd(OPND_MEM, RSI, RDI), 2'd1, 32'h8, 32'h0, 32'h700);
        vo[5] = m_lea; vn[5] = 1;
        ve[5][0] = mk_uop(m_lea, RDX, RDX, RSI, vi[5]);
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            in_inst = vi[v]; in_alu_op = vo[v]; in_valid = 1'b1;
            next_cycle();
            in_valid = 1'b0;
            for (int k = 0; k < vn[v]; k++) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL form%0d_valid%0d got=%b exp=1", v, k, out_valid); end
                total++; if (out_uop !== ve[v][k]) begin bad++; $display("FAIL form%0d_uop%0d got=%h exp=%h", v, k, out_uop, ve[v][k]); end
                total++; if (out_last !== (k == vn[v] - 1)) begin bad++; $display("FAIL form%0d_last%0d got=%b exp=%b", v, k, out_last, (k == vn[v] - 1)); end
                next_cycle();
            end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL form%0d_end got=%b exp=0", v, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        fat_instruction_t f;
        micro_op_t        e1, e2;
        f  = mk_inst(mk_opnd(OPND_MEM, RBP, NOR), mk_opnd(OPND_IMM, NOR, NOR), 2'd0, 32'hFFFF_FFF8, 32'hFF, 32'h800);
        e1 = mk_uop(m_or, TMP, TMP, NOR, f);
        e2 = mk_uop(m_st, TMP, RBP, NOR, f);
        in_inst = f; in_alu_op = m_or; in_valid = 1'b1; out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%b exp=1", c, out_valid); end
            total++; if (out_uop !== e1) begin bad++; $display("FAIL bp_uop%0d got=%h exp=%h", c, out_uop, e1); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got=%b exp=0", c, in_ready); end
            next_cycle();
        end
        out_ready = 1'b1;
        #1;
        total++; if (out_uop !== e1) begin bad++; $display("FAIL bp_release got=%h exp=%h", out_uop, e1); end
        next_cycle();
        total++; if (out_uop !== e2 || out_last !== 1'b1) begin bad++; $display("FAIL bp_store got=%h/%b exp=%h/1", out_uop, out_last, e2); end
        next_cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_end got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        fat_instruction_t fa, fb;
        micro_op_t        ea, eb;
        fa = mk_inst(mk_opnd(OPND_REG, RAX, NOR), mk_opnd(OPND_REG, RBX, NOR), 2'd0, 32'h0, 32'h0, 32'h900);
        fb = mk_inst(mk_opnd(OPND_REG, RDX, NOR), mk_opnd(OPND_REG, RCX, NOR), 2'd0, 32'h0, 32'h0, 32'h904);
        ea = mk_uop(m_add, RAX, RAX, RBX, fa);
        eb = mk_uop(m_xor, RDX, RDX, RCX, fb);
        out_ready = 1'b1;
        in_inst = fa; in_alu_op = m_add; in_valid = 1'b1;
        next_cycle();
        in_inst = fb; in_alu_op = m_xor;
        #1;
        total++; if (out_valid !== 1'b1 || out_uop !== ea) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/%h", out_valid, out_uop, ea); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        next_cycle();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_uop !== eb) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/%h", out_valid, out_uop, eb); end
        next_cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        in_inst = mk_inst(mk_opnd(OPND_MEM, RAX, NOR), mk_opnd(OPND_MEM, RBX, NOR), 2'd0, 32'h0, 32'h0, 32'hA00);
        in_alu_op = m_add; in_valid = 1'b1; out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        total++; if (err_illegal !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", err_illegal); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ill_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ill_in_ready got=%b exp=1", in_ready); end
        next_cycle();
        total++; if (err_illegal !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL ill_after got=%b/%b exp=0/0", err_illegal, out_valid); end
    endtask

    task automatic test_reset_mid();
        in_inst = mk_inst(mk_opnd(OPND_MEM, RBP, NOR), mk_opnd(OPND_IMM, NOR, NOR), 2'd0, 32'hFFFF_FFF8, 32'hFF, 32'hB00);
        in_alu_op = m_or; in_valid = 1'b1; out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        total++; if (out_uop.opcode !== m_or) begin bad++; $display("FAIL rm_idx1 got=%0d exp=%0d", out_uop.opcode, m_or); end
        reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_drop got=%b exp=0", out_valid); end
        total++; if (out_uop !== micro_op_t'('0)) begin bad++; $display("FAIL rm_uop got=%h exp=0", out_uop); end
        repeat (2) next_cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_no_resume%0d got=%b exp=0", c, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_reg_add();
        test_crack_forms();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
